alu_operand_sequencer: RTL and testbench

- Upstream control stage for the 8-bit lab ALU and 7-segment decoders on the DE1 board.
- The user enters operand A, operand B and the opcode/carry in turn on the switches, confirming each with a debounced push-button.
- The block holds the registered A, B, sel and car_in steady on the ALU inputs, then latches the ALU result in a result register.
- It also selects the 8-bit value sent to the two hex decoders: live switch value while entering, latched result while showing.

---
 rtl/alu_operand_sequencer_if.sv | 27 ++
 rtl/alu_operand_sequencer.sv | 137 +++++++++++++
 tb/tb_alu_operand_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_sequencer_if.sv
// Switch/key inputs, ALU operand and result bus, and display outputs of the
// DE1 ALU operand sequencer.
interface alu_operand_sequencer_if;
  logic [7:0] data_in;
  logic [4:0] sel_in;
  logic       cin_in;
  logic       key_n;
  logic [7:0] alu_result;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [4:0] sel;
  logic       car_in;
  logic [7:0] result_q;
  logic [7:0] disp;
  logic [2:0] state;
  logic       done;

  modport master (
    output data_in, sel_in, cin_in, key_n, alu_result,
    input  op_a, op_b, sel, car_in, result_q, disp, state, done
  );

  modport slave (
    input  data_in, sel_in, cin_in, key_n, alu_result,
    output op_a, op_b, sel, car_in, result_q, disp, state, done
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Collects A, B and opcode/carry from switches on debounced key presses,
// holds them on the ALU inputs and latches the ALU result for display.
module alu_operand_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input logic                     CLOCK_50,
  input logic                     RESET_N,
  alu_operand_sequencer_if.slave  bus
);

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned SEL_W   = 5;
  localparam int unsigned STATE_W = 3;

  localparam logic [2:0] GET_A  = 3'd0;
  localparam logic [2:0] GET_B  = 3'd1;
  localparam logic [2:0] GET_OP = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] SHOW   = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               sync1_q, sync2_q;
  logic               deb_q, deb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               press_q, press_d;

  logic [STATE_W-1:0] state_q, state_d;
  logic [DATA_W-1:0]  op_a_q, op_a_d;
  logic [DATA_W-1:0]  op_b_q, op_b_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               car_in_q, car_in_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  disp_c;

  // Debounce: accept a new level only after it has been stable long enough
  always_comb begin
    deb_d   = deb_q;
    cnt_d   = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    press_d = deb_q & ~deb_d;
  end

  // Sequencer: captures happen only on the transition that leaves a state
  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    sel_d    = sel_q;
    car_in_d = car_in_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      GET_A: if (press_q) begin
        op_a_d  = bus.data_in;
        state_d = GET_B;
      end
      GET_B: if (press_q) begin
        op_b_d  = bus.data_in;
        state_d = GET_OP;
      end
      GET_OP: if (press_q) begin
        sel_d    = bus.sel_in;
        car_in_d = bus.cin_in;
        state_d  = EXEC;
      end
      EXEC: begin
        result_d = bus.alu_result;
        done_d   = 1'b1;
        state_d  = SHOW;
      end
      SHOW: if (press_q) begin
        state_d = GET_A;
      end
      default: state_d = GET_A;
    endcase
  end

  // Live switches while entering, latched result once computed
  always_comb begin
    disp_c = bus.data_in;
    case (state_q)
      GET_OP:     disp_c = {3'b000, bus.sel_in};
      EXEC, SHOW: disp_c = result_q;
      default:    disp_c = bus.data_in;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      deb_q    <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
      state_q  <= GET_A;
      op_a_q   <= '0;
      op_b_q   <= '0;
      sel_q    <= '0;
      car_in_q <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      sync1_q  <= bus.key_n;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      sel_q    <= sel_d;
      car_in_q <= car_in_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.op_a     = op_a_q;
  assign bus.op_b     = op_b_q;
  assign bus.sel      = sel_q;
  assign bus.car_in   = car_in_q;
  assign bus.result_q = result_q;
  assign bus.disp     = disp_c;
  assign bus.state    = state_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a short debounce window and
// an adder standing in for the ALU.
module tb_alu_operand_sequencer;

  localparam int unsigned DEB = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   n;
  int   advances;
  logic [2:0] prev_state;

  always #5 clk = ~clk;

  alu_operand_sequencer_if bus ();

  assign bus.alu_result = bus.op_a + bus.op_b;

  alu_operand_sequencer #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .bus      (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Clean press: state must advance DEB+3 edges after the raw falling edge
  task automatic press(input string tag);
    logic [2:0] s0;
    int k;
    s0 = bus.state;
    bus.key_n = 1'b0;
    k = 0;
    while (bus.state === s0 && k < 64) begin
      tick(1);
      k++;
    end
    check({tag, "_latency"}, k, DEB + 3);
    bus.key_n = 1'b1;
    tick(DEB + 4);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.key_n   = 1'b1;
    bus.data_in = 8'h3C;
    bus.sel_in  = 5'd0;
    bus.cin_in  = 1'b0;
    tick(3);
    check("rst_state",  bus.state,    3'd0);
    check("rst_op_a",   bus.op_a,     8'h00);
    check("rst_op_b",   bus.op_b,     8'h00);
    check("rst_sel",    bus.sel,      5'd0);
    check("rst_car",    bus.car_in,   1'b0);
    check("rst_result", bus.result_q, 8'h00);
    check("rst_done",   bus.done,     1'b0);
    check("rst_disp",   bus.disp,     8'h3C);
    rst_n = 1'b1;
    tick(2);

    // Reset asserted mid-operation in GET_B
    bus.data_in = 8'h56;
    press("t1_a");
    check("t1_state_b", bus.state, 3'd1);
    check("t1_op_a",    bus.op_a,  8'h56);
    bus.data_in = 8'h21;
    tick(1);
    check("t1_disp_b",  bus.disp,  8'h21);
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_state",  bus.state,    3'd0);
    check("t1_async_op_a",   bus.op_a,     8'h00);
    check("t1_async_result", bus.result_q, 8'h00);
    check("t1_async_done",   bus.done,     1'b0);
    check("t1_async_disp",   bus.disp,     8'h21);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Full sequence: 0x56 + 0xB5 = 0x10B, wraps to 0x0B
    bus.data_in = 8'h56;
    press("t2_a");
    bus.data_in = 8'hB5;
    press("t2_b");
    check("t2_state_op", bus.state, 3'd2);
    check("t2_op_b",     bus.op_b,  8'hB5);
    bus.sel_in = 5'b00010;
    bus.cin_in = 1'b0;
    tick(1);
    check("t2_disp_op", bus.disp, 8'h02);
    bus.key_n = 1'b0;
    n = 0;
    while (bus.state === 3'd2 && n < 64) begin
      tick(1);
      n++;
    end
    check("t2_op_latency", n,          DEB + 3);
    check("t2_exec",       bus.state,  3'd3);
    check("t2_exec_done",  bus.done,   1'b0);
    check("t2_sel",        bus.sel,    5'b00010);
    check("t2_car",        bus.car_in, 1'b0);
    tick(1);
    check("t2_show",        bus.state,    3'd4);
    check("t2_done_pulse",  bus.done,     1'b1);
    check("t2_result",      bus.result_q, 8'h0B);
    check("t2_disp_result", bus.disp,     8'h0B);
    tick(1);
    check("t2_done_low",    bus.done,     1'b0);
    check("t2_still_show",  bus.state,    3'd4);
    bus.key_n = 1'b1;
    tick(DEB + 4);
    check("t2_release_idle", bus.state, 3'd4);

    // Operand stability while switches churn in SHOW
    for (int i = 0; i < 20; i++) begin
      bus.data_in = 8'($urandom);
      bus.sel_in  = 5'($urandom);
      bus.cin_in  = 1'($urandom);
      tick(1);
      check("t6_op_a",   bus.op_a,     8'h56);
      check("t6_op_b",   bus.op_b,     8'hB5);
      check("t6_sel",    bus.sel,      5'b00010);
      check("t6_car",    bus.car_in,   1'b0);
      check("t6_result", bus.result_q, 8'h0B);
      check("t6_state",  bus.state,    3'd4);
    end

    // SHOW + press returns to GET_A with registers retained
    bus.data_in = 8'hFF;
    press("t5_show");
    check("t5_state",  bus.state,    3'd0);
    check("t5_op_a",   bus.op_a,     8'h56);
    check("t5_op_b",   bus.op_b,     8'hB5);
    check("t5_result", bus.result_q, 8'h0B);
    check("t5_disp",   bus.disp,     8'hFF);

    // Held key: one advance only
    bus.data_in = 8'h9A;
    bus.key_n   = 1'b0;
    advances    = 0;
    prev_state  = bus.state;
    repeat (1000) begin
      tick(1);
      if (bus.state !== prev_state) advances++;
      prev_state = bus.state;
    end
    check("t4_advances", advances,  1);
    check("t4_state",    bus.state, 3'd1);
    check("t4_op_a",     bus.op_a,  8'h9A);
    check("t4_op_b",     bus.op_b,  8'hB5);
    bus.key_n = 1'b1;
    tick(DEB + 4);

    // Bounce: 2-cycle toggles never satisfy the window, final fall does
    bus.data_in = 8'h11;
    for (int i = 0; i < 10; i++) begin
      bus.key_n = ~bus.key_n;
      tick(2);
    end
    check("t3_no_early_advance", bus.state, 3'd1);
    bus.key_n = 1'b0;
    n = 0;
    while (bus.state === 3'd1 && n < 64) begin
      tick(1);
      n++;
    end
    check("t3_latency", n,         DEB + 3);
    check("t3_state",   bus.state, 3'd2);
    check("t3_op_b",    bus.op_b,  8'h11);
    tick(20);
    check("t3_single",  bus.state, 3'd2);
    bus.key_n = 1'b1;
    tick(DEB + 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
